apb4_master_arb: RTL and testbench

- Two-requester APB4 master that shares one APB4 bus between two internal requesters.
- Arbitrates round-robin, sequences the IDLE/SETUP/ACCESS protocol, decodes two slave selects (PSEL1/PSEL2) and returns the response to the granted requester.
- Sits between on-chip requesters (e.g. a CPU port and a DMA port) and the APB4 memory slaves.

---
 rtl/apb4_master_arb_if.sv | 46 ++++
 rtl/apb4_master_arb.sv | 125 ++++++++++++
 tb/tb_apb4_master_arb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_master_arb_if.sv
// Requester-side and APB-side signal bundle for apb4_master_arb.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb4_master_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [1:0]              REQ_VALID;
  logic [1:0]              REQ_READY;
  logic [2*ADDR_WIDTH-1:0] REQ_ADDR;
  logic [1:0]              REQ_WRITE;
  logic [2*DATA_WIDTH-1:0] REQ_WDATA;
  logic [2*STRB_WIDTH-1:0] REQ_STRB;
  logic [1:0]              RSP_VALID;
  logic [DATA_WIDTH-1:0]   RSP_RDATA;
  logic                    RSP_ERR;

  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSEL1;
  logic                    PSEL2;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [STRB_WIDTH-1:0]   PSTRB;
  logic                    PREADY1;
  logic                    PREADY2;
  logic [DATA_WIDTH-1:0]   PRDATA1;
  logic [DATA_WIDTH-1:0]   PRDATA2;
  logic                    PSLVERR1;
  logic                    PSLVERR2;

  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_WDATA, REQ_STRB,
    input  PREADY1, PREADY2, PRDATA1, PRDATA2, PSLVERR1, PSLVERR2,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_WDATA, REQ_STRB,
    output PREADY1, PREADY2, PRDATA1, PRDATA2, PSLVERR1, PSLVERR2,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb4_master_arb.sv
// Two-requester round-robin APB4 master driving two slaves selected by PADDR MSB.
// Optional ACCESS-phase timeout is compiled in with `define APB4_ARB_TIMEOUT_EN.
module apb4_master_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32
`ifdef APB4_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic               PCLK,
  input logic               PRESET,
  apb4_master_arb_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic                  rr;     // requester favoured when both are valid
  logic                  gnt;    // owner of the in-flight transfer
  logic                  grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_g;
  logic                  write_g;
  logic [DATA_WIDTH-1:0] wdata_g;
  logic [STRB_WIDTH-1:0] strb_g;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  logic                  timeout;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = bus.REQ_VALID[1];
    if (&bus.REQ_VALID) grant = rr;
  end

  assign accept        = (state == IDLE) && (|bus.REQ_VALID);
  assign bus.REQ_READY = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign addr_g  = grant ? bus.REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.REQ_ADDR[ADDR_WIDTH-1:0];
  assign write_g = grant ? bus.REQ_WRITE[1] : bus.REQ_WRITE[0];
  assign wdata_g = grant ? bus.REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : bus.REQ_WDATA[DATA_WIDTH-1:0];
  assign strb_g  = grant ? bus.REQ_STRB[2*STRB_WIDTH-1:STRB_WIDTH] : bus.REQ_STRB[STRB_WIDTH-1:0];

  // Only the selected slave's response is observed.
  assign pready  = bus.PSEL2 ? bus.PREADY2  : bus.PREADY1;
  assign prdata  = bus.PSEL2 ? bus.PRDATA2  : bus.PRDATA1;
  assign pslverr = bus.PSEL2 ? bus.PSLVERR2 : bus.PSLVERR1;

`ifdef APB4_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  // Expiry is judged on the edge that would make the count reach the limit.
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      rr            <= 1'b0;
      gnt           <= 1'b0;
      bus.PADDR     <= '0;
      bus.PSEL1     <= 1'b0;
      bus.PSEL2     <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
      bus.PSTRB     <= '0;
      bus.RSP_VALID <= 2'b00;
      bus.RSP_RDATA <= '0;
      bus.RSP_ERR   <= 1'b0;
`ifdef APB4_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      bus.RSP_VALID <= 2'b00;
      bus.RSP_RDATA <= '0;
      bus.RSP_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            gnt        <= grant;
            rr         <= ~grant;
            bus.PADDR  <= addr_g;
            bus.PWRITE <= write_g;
            bus.PWDATA <= write_g ? wdata_g : '0;
            bus.PSTRB  <= write_g ? strb_g : '0;
            bus.PSEL1  <= ~addr_g[ADDR_WIDTH-1];
            bus.PSEL2  <= addr_g[ADDR_WIDTH-1];
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
`ifdef APB4_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        ACCESS: begin
          if (pready || timeout) begin
            bus.PSEL1     <= 1'b0;
            bus.PSEL2     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.RSP_VALID <= gnt ? 2'b10 : 2'b01;
            bus.RSP_ERR   <= pready ? pslverr : 1'b1;
            bus.RSP_RDATA <= (pready && !bus.PWRITE && !pslverr) ? prdata : '0;
            state         <= IDLE;
          end
`ifdef APB4_ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb4_master_arb.sv
// Directed self-checking bench for apb4_master_arb: reads, writes, round-robin,
// wait states with error, mid-transfer reset and the ACCESS wait limit.
module tb_apb4_master_arb;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef APB4_ARB_TIMEOUT_EN
  localparam int TO = 4;
`endif

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0;
  int   errors = 0;
  int   penable_cnt;
  logic [1:0]  exp_g;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;

  apb4_master_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb4_master_arb #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
`ifdef APB4_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    bus.REQ_ADDR[i*AW +: AW]  = addr;
    bus.REQ_WRITE[i]          = wr;
    bus.REQ_WDATA[i*DW +: DW] = wdata;
    bus.REQ_STRB[i*4 +: 4]    = strb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    PRESET        = 1'b1;
    bus.REQ_VALID = '0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WRITE = '0;
    bus.REQ_WDATA = '0;
    bus.REQ_STRB  = '0;
    bus.PREADY1   = 1'b0;
    bus.PREADY2   = 1'b0;
    bus.PRDATA1   = '0;
    bus.PRDATA2   = '0;
    bus.PSLVERR1  = 1'b0;
    bus.PSLVERR2  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_psel1", bus.PSEL1, 0);
    check("rst_psel2", bus.PSEL2, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_pstrb", bus.PSTRB, 0);
    check("rst_rsp_valid", bus.RSP_VALID, 0);
    check("rst_rsp_rdata", bus.RSP_RDATA, 0);
    check("rst_rsp_err", bus.RSP_ERR, 0);
    check("rst_req_ready", bus.REQ_READY, 0);
    PRESET = 1'b0;
    step();

    // Zero-wait read from requester 0 to slave 1
    set_req(0, 32'h0000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF);
    bus.REQ_VALID = 2'b01;
    bus.PREADY1   = 1'b1;
    bus.PRDATA1   = 32'hDEAD_BEEF;
    #1;
    check("t1_req_ready", bus.REQ_READY, 2'b01);
    step();
    bus.REQ_VALID = 2'b00;
    check("t1_setup_psel1", bus.PSEL1, 1);
    check("t1_setup_psel2", bus.PSEL2, 0);
    check("t1_setup_penable", bus.PENABLE, 0);
    check("t1_setup_paddr", bus.PADDR, 32'h0000_0004);
    check("t1_setup_pwrite", bus.PWRITE, 0);
    check("t1_read_pwdata", bus.PWDATA, 0);
    check("t1_read_pstrb", bus.PSTRB, 0);
    step();
    check("t1_access_penable", bus.PENABLE, 1);
    check("t1_access_psel1", bus.PSEL1, 1);
    step();
    check("t1_rsp_valid", bus.RSP_VALID, 2'b01);
    check("t1_rsp_rdata", bus.RSP_RDATA, 32'hDEAD_BEEF);
    check("t1_rsp_err", bus.RSP_ERR, 0);
    check("t1_idle_penable", bus.PENABLE, 0);
    check("t1_idle_psel1", bus.PSEL1, 0);
    step();
    check("t1_rsp_one_cycle", bus.RSP_VALID, 2'b00);

    // Write with strobes from requester 1 to slave 2
    set_req(1, 32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101);
    bus.REQ_VALID = 2'b10;
    bus.PREADY1   = 1'b0;
    bus.PREADY2   = 1'b1;
    bus.PRDATA2   = 32'hCAFE_F00D;
    #1;
    check("t2_req_ready", bus.REQ_READY, 2'b10);
    step();
    bus.REQ_VALID = 2'b00;
    set_req(1, 32'h0, 1'b0, 32'h0, 4'h0);
    check("t2_setup_psel2", bus.PSEL2, 1);
    check("t2_setup_psel1", bus.PSEL1, 0);
    check("t2_setup_pwrite", bus.PWRITE, 1);
    check("t2_setup_paddr", bus.PADDR, 32'h8000_0010);
    check("t2_setup_pwdata", bus.PWDATA, 32'h1122_3344);
    check("t2_setup_pstrb", bus.PSTRB, 4'b0101);
    step();
    check("t2_access_penable", bus.PENABLE, 1);
    check("t2_access_paddr", bus.PADDR, 32'h8000_0010);
    check("t2_access_pwdata", bus.PWDATA, 32'h1122_3344);
    check("t2_access_pstrb", bus.PSTRB, 4'b0101);
    check("t2_access_pwrite", bus.PWRITE, 1);
    step();
    check("t2_rsp_valid", bus.RSP_VALID, 2'b10);
    check("t2_rsp_rdata", bus.RSP_RDATA, 0);
    check("t2_rsp_err", bus.RSP_ERR, 0);

    // Three wait states then completion with PSLVERR; slave 2 ready is ignored
    set_req(0, 32'h0000_0008, 1'b0, 32'h0, 4'h0);
    bus.REQ_VALID = 2'b01;
    bus.PREADY1   = 1'b0;
    bus.PRDATA1   = 32'h1234_5678;
    bus.PREADY2   = 1'b1;
    #1;
    check("t4_req_ready", bus.REQ_READY, 2'b01);
    step();
    bus.REQ_VALID = 2'b00;
    penable_cnt   = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      penable_cnt += int'(bus.PENABLE);
      check($sformatf("t4_wait%0d_no_rsp", c), bus.RSP_VALID, 2'b00);
    end
    step();
    penable_cnt += int'(bus.PENABLE);
    bus.PREADY1  = 1'b1;
    bus.PSLVERR1 = 1'b1;
    step();
    penable_cnt += int'(bus.PENABLE);
    check("t4_penable_cycles", penable_cnt, 4);
    check("t4_rsp_valid", bus.RSP_VALID, 2'b01);
    check("t4_rsp_err", bus.RSP_ERR, 1);
    check("t4_rsp_rdata", bus.RSP_RDATA, 0);
    bus.PSLVERR1 = 1'b0;
    bus.PREADY1  = 1'b0;
    bus.PREADY2  = 1'b0;

    // Reset during ACCESS abandons the transfer
    set_req(0, 32'h0000_000C, 1'b0, 32'h0, 4'h0);
    bus.REQ_VALID = 2'b01;
    #1;
    check("t5_req_ready", bus.REQ_READY, 2'b01);
    step();
    bus.REQ_VALID = 2'b00;
    step();
    check("t5_in_access", bus.PENABLE, 1);
    PRESET      = 1'b1;
    bus.PREADY1 = 1'b1;
    step();
    check("t5_psel1", bus.PSEL1, 0);
    check("t5_penable", bus.PENABLE, 0);
    check("t5_rsp_valid", bus.RSP_VALID, 2'b00);
    PRESET = 1'b0;
    step();
    check("t5_no_late_rsp", bus.RSP_VALID, 2'b00);

    // Contention after reset: alternating grants, back-to-back every 3 cycles
    set_req(0, 32'h0000_0100, 1'b0, 32'h0, 4'h0);
    set_req(1, 32'h8000_0200, 1'b0, 32'h0, 4'h0);
    bus.PRDATA1   = 32'hA5A5_0001;
    bus.PRDATA2   = 32'h5A5A_0002;
    bus.PREADY1   = 1'b1;
    bus.PREADY2   = 1'b1;
    bus.REQ_VALID = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_g    = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 1) ? 32'h8000_0200 : 32'h0000_0100;
      exp_data = (i % 2 == 1) ? 32'h5A5A_0002 : 32'hA5A5_0001;
      check($sformatf("t3_grant%0d", i), bus.REQ_READY, exp_g);
      step();
      check($sformatf("t3_paddr%0d", i), bus.PADDR, exp_addr);
      step();
      step();
      check($sformatf("t3_rsp_valid%0d", i), bus.RSP_VALID, exp_g);
      check($sformatf("t3_rsp_rdata%0d", i), bus.RSP_RDATA, exp_data);
    end
    bus.REQ_VALID = 2'b00;
    step();
    check("t3_idle_after", {bus.PSEL2, bus.PSEL1}, 2'b00);
    bus.PREADY1 = 1'b0;
    bus.PREADY2 = 1'b1;

    // ACCESS with a slave that never becomes ready
    set_req(0, 32'h0000_0014, 1'b0, 32'h0, 4'h0);
    bus.PRDATA1   = 32'h0000_0077;
    bus.REQ_VALID = 2'b01;
    #1;
    check("t6_req_ready", bus.REQ_READY, 2'b01);
    step();
    bus.REQ_VALID = 2'b00;
`ifdef APB4_ARB_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      step();
      check($sformatf("t6_access%0d_penable", c), bus.PENABLE, 1);
    end
    step();
    check("t6_to_rsp_valid", bus.RSP_VALID, 2'b01);
    check("t6_to_rsp_err", bus.RSP_ERR, 1);
    check("t6_to_rsp_rdata", bus.RSP_RDATA, 0);
    check("t6_to_penable", bus.PENABLE, 0);
`else
    for (int c = 0; c < 100; c++) step();
    check("t6_still_penable", bus.PENABLE, 1);
    check("t6_still_psel1", bus.PSEL1, 1);
    check("t6_no_rsp", bus.RSP_VALID, 2'b00);
    bus.PREADY1 = 1'b1;
    step();
    check("t6_late_rsp_valid", bus.RSP_VALID, 2'b01);
    check("t6_late_rsp_err", bus.RSP_ERR, 0);
    check("t6_late_rsp_rdata", bus.RSP_RDATA, 32'h0000_0077);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
